// File: rtl/mem_copy_engine.sv
// Block-copy initiator for the single-port memory controller.
// Copies in ascending two-word chunks, with a one-word chunk for an odd tail.
module mem_copy_engine #(
  parameter int M_WIDTH = 8,
  parameter int M_DEPTH = 8192,
  localparam int AW = $clog2(M_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [AW-1:0]      src_addr,
  input  logic [AW-1:0]      dst_addr,
  input  logic [AW:0]        len,
  output logic               busy,
  output logic               done,
  output logic [2:0]         cmd,
  output logic [AW-1:0]      addr,
  output logic [M_WIDTH-1:0] din1,
  output logic [M_WIDTH-1:0] din2,
  input  logic [M_WIDTH-1:0] dout1,
  input  logic [M_WIDTH-1:0] dout2,
  input  logic               op_cplt_flag
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_REL,
    WR_ISSUE,
    WR_WAIT,
    WR_REL,
    FINISH
  } state_t;

  state_t             state;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [AW:0]        remaining;
  logic [M_WIDTH-1:0] buf1;
  logic [M_WIDTH-1:0] buf2;
  logic               two;

  logic [AW-1:0] step;
  logic          len_two;
  logic          rem_two;

  // Chunk size is 2 when two-word, else 1.
  assign step    = {{(AW-1){1'b0}}, two, ~two};
  assign len_two = |len[AW:1];
  assign rem_two = |remaining[AW:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      remaining <= '0;
      buf1      <= '0;
      buf2      <= '0;
      two       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd       <= 3'b000;
      addr      <= '0;
      din1      <= '0;
      din2      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rd_ptr    <= src_addr;
            wr_ptr    <= dst_addr;
            remaining <= len;
            busy      <= 1'b1;
            if (len == '0) begin
              state <= FINISH;
            end else begin
              two   <= len_two;
              cmd   <= {2'b10, len_two};
              addr  <= src_addr;
              state <= RD_WAIT;
            end
          end
        end
        RD_ISSUE: begin
          two   <= rem_two;
          cmd   <= {2'b10, rem_two};
          addr  <= rd_ptr;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (op_cplt_flag) begin
            buf1 <= dout1;
            if (two) buf2 <= dout2;
            cmd   <= 3'b000;
            state <= RD_REL;
          end
        end
        RD_REL: begin
          if (!op_cplt_flag) state <= WR_ISSUE;
        end
        WR_ISSUE: begin
          cmd  <= {2'b11, two};
          addr <= wr_ptr;
          din1 <= buf1;
          if (two) din2 <= buf2;
          state <= WR_WAIT;
        end
        WR_WAIT: begin
          if (op_cplt_flag) begin
            cmd       <= 3'b000;
            rd_ptr    <= rd_ptr + step;
            wr_ptr    <= wr_ptr + step;
            remaining <= remaining - {1'b0, step};
            state     <= WR_REL;
          end
        end
        WR_REL: begin
          if (!op_cplt_flag) begin
            if (remaining != '0) state <= RD_ISSUE;
            else state <= FINISH;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: controller/memory model plus chunk-level
// reference copy, directed and random copies, reset and busy-start cases.
module tb_mem_copy_engine;

  localparam int MW = 8;
  localparam int MD = 8192;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_addr, dst_addr;
  logic [AW:0]   len;
  logic          busy, done;
  logic [2:0]    cmd;
  logic [AW-1:0] addr;
  logic [MW-1:0] din1, din2, dout1, dout2;
  logic          op_cplt_flag;

  always #5 clk = ~clk;

  mem_copy_engine #(.M_WIDTH(MW), .M_DEPTH(MD)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .cmd(cmd), .addr(addr),
    .din1(din1), .din2(din2), .dout1(dout1), .dout2(dout2),
    .op_cplt_flag(op_cplt_flag)
  );

  typedef struct {
    logic [2:0]    c;
    logic [AW-1:0] a;
    logic [MW-1:0] d1;
    logic [MW-1:0] d2;
  } cmd_t;

  logic [MW-1:0] mem [MD];
  logic [MW-1:0] exp_mem [MD];
  cmd_t obs_q[$];
  cmd_t exp_q[$];

  int checks = 0;
  int passed = 0;
  int proto_err = 0;

  // Controller model: busy N cycles, flag held until cmd[2] drops.
  logic          active;
  int            cnt;
  cmd_t          cur;
  logic [AW-1:0] a2;

  function automatic int nlen(logic [2:0] c);
    case (c)
      3'b101:  return 4;
      3'b100:  return 3;
      3'b111:  return 3;
      default: return 2;
    endcase
  endfunction

  assign a2 = cur.a + 13'd1;

  always @(posedge clk) begin
    if (rst) begin
      active       <= 1'b0;
      op_cplt_flag <= 1'b0;
      cnt          <= 0;
      dout1        <= '0;
      dout2        <= '0;
    end else if (!active) begin
      if (cmd[2]) begin
        active <= 1'b1;
        cnt    <= 1;
        cur    <= '{cmd, addr, din1, din2};
        obs_q.push_back('{cmd, addr, din1, din2});
      end
    end else if (!op_cplt_flag) begin
      if (cmd !== cur.c || addr !== cur.a) proto_err++;
      if (cur.c[1] && din1 !== cur.d1) proto_err++;
      if (cnt == nlen(cur.c) - 1) begin
        op_cplt_flag <= 1'b1;
        if (cur.c[1]) begin
          mem[cur.a] = cur.d1;
          if (cur.c[0]) mem[a2] = cur.d2;
        end else begin
          dout1 <= mem[cur.a];
          dout2 <= mem[a2];
        end
      end else begin
        cnt <= cnt + 1;
      end
    end else if (!cmd[2]) begin
      op_cplt_flag <= 1'b0;
      active       <= 1'b0;
    end else if (cmd !== cur.c) begin
      proto_err++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  // Reference: ascending chunks, each chunk read fully before written.
  task automatic model(input int s, input int d, input int n);
    int rp, wp, rem, k;
    logic [MW-1:0] w1, w2;
    exp_q.delete();
    exp_mem = mem;
    rp = s; wp = d; rem = n;
    while (rem > 0) begin
      k = (rem >= 2) ? 2 : 1;
      w1 = exp_mem[rp];
      w2 = exp_mem[(rp + 1) % MD];
      exp_q.push_back('{(k == 2) ? 3'b101 : 3'b100, AW'(rp), 8'h0, 8'h0});
      exp_q.push_back('{(k == 2) ? 3'b111 : 3'b110, AW'(wp), w1, w2});
      exp_mem[wp] = w1;
      if (k == 2) exp_mem[(wp + 1) % MD] = w2;
      rp = (rp + k) % MD;
      wp = (wp + k) % MD;
      rem -= k;
    end
  endtask

  task automatic run_copy(input int s, input int d, input int n,
                          input int inject_at);
    int t, k, bz, bad, after;
    bit seen;
    model(s, d, n);
    obs_q.delete();
    proto_err = 0;
    t = (n == 0) ? 1 : 15 * (n / 2) + 13 * (n % 2);
    @(negedge clk);
    src_addr = AW'(s);
    dst_addr = AW'(d);
    len = (AW + 1)'(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_at_start", 32'(busy), 1);
    if (n == 0) chk("cmd_at_start", 32'(cmd), 0);
    else chk("cmd_at_start", 32'(cmd), (n >= 2) ? 5 : 4);
    k = 0; bz = 0; seen = 0;
    while (k < t + 40 && !seen) begin
      @(posedge clk);
      #1;
      k++;
      if (done) seen = 1;
      else if (busy !== 1'b1) bz++;
      if (k == inject_at) begin
        src_addr = AW'($urandom);
        dst_addr = AW'($urandom);
        len = (AW + 1)'($urandom_range(1, 9));
        start = 1'b1;
      end
      if (k == inject_at + 1) start = 1'b0;
    end
    chk("done_cycle", k, t);
    chk("busy_high_til_done", bz, 0);
    chk("busy_low_at_done", 32'(busy), 0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 0);
    after = obs_q.size();
    repeat (20) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0 || done !== 1'b0) bz++;
    end
    chk("idle_after_done", bz, 0);
    chk("no_extra_cmds", obs_q.size(), after);
    chk("cmd_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk("cmd", 32'(obs_q[i].c), 32'(exp_q[i].c));
      chk("addr", 32'(obs_q[i].a), 32'(exp_q[i].a));
      if (exp_q[i].c[1]) chk("din1", 32'(obs_q[i].d1), 32'(exp_q[i].d1));
      if (exp_q[i].c == 3'b111)
        chk("din2", 32'(obs_q[i].d2), 32'(exp_q[i].d2));
    end
    bad = 0;
    for (int i = 0; i < MD; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk("mem_contents", bad, 0);
    chk("cmd_hold", proto_err, 0);
  endtask

  initial begin
    int n, bz, w;
    for (int i = 0; i < MD; i++) mem[i] = MW'($urandom);
    rst = 1'b1;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd", 32'(cmd), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_din1", 32'(din1), 0);
    chk("rst_din2", 32'(din2), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;

    run_copy(0, 0, 0, -1);

    mem[16] = 8'hA5;
    mem[17] = 8'h3C;
    run_copy(16, 32, 2, -1);
    chk("pair_d1", 32'(mem[32]), 32'hA5);
    chk("pair_d2", 32'(mem[33]), 32'h3C);

    for (int i = 0; i < 5; i++) mem[i] = MW'(i + 1);
    run_copy(0, 64, 5, -1);
    for (int i = 0; i < 5; i++) chk("len5_mem", 32'(mem[64 + i]), i + 1);

    run_copy(MD - 1, 256, 3, -1);
    chk("wrap_rd0", 32'(exp_q[0].a), MD - 1);
    chk("wrap_rd1", 32'(exp_q[2].a), 1);

    run_copy(1000, 2000, 6, 10);

    for (int r = 0; r < 8; r++)
      run_copy($urandom_range(0, MD - 1), $urandom_range(0, MD - 1),
               $urandom_range(1, 12), -1);
    run_copy(500, 501, 7, -1);

    // Reset in the middle of a two-word read.
    obs_q.delete();
    @(negedge clk);
    src_addr = 13'h200;
    dst_addr = 13'h300;
    len = 14'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    w = 0;
    while (!(active && cur.c == 3'b101) && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("rd2_in_flight", 32'(cmd), 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_cmd", 32'(cmd), 0);
    chk("mid_rst_addr", 32'(addr), 0);
    chk("mid_rst_din", 32'({din1, din2}), 0);
    chk("mid_rst_busy", 32'({busy, done}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = obs_q.size();
    bz = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (cmd !== 3'b000 || busy !== 1'b0 || done !== 1'b0) bz++;
    end
    chk("post_rst_quiet", bz, 0);
    chk("post_rst_no_cmd", obs_q.size(), n);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
